// File: rtl/pixel_stream_buffer.sv
// RGB332 AXI-Stream to RGB444 VGA pixel path: expands each accepted byte, buffers it in a
// show-ahead FIFO, and pops one pixel per pixel-clock tick inside the visible area.
module pixel_stream_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int PIXEL_WIDTH = 12,
  parameter int ADDR_WIDTH  = 10,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic                   i_CLK,
  input  logic                   i_RSTn,
  input  logic [DATA_WIDTH-1:0]  S_AXIS_DATA,
  input  logic                   S_AXIS_VALID,
  output logic                   S_AXIS_READY,
  input  logic                   TICK_25,
  input  logic [10:0]            HC,
  input  logic [10:0]            VC,
  output logic [PIXEL_WIDTH-1:0] D_2_VGA,
  output logic                   FIFO_FULL,
  output logic                   FIFO_EMPTY,
  output logic                   UNDERFLOW
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Handshake: a beat transfers on a rising edge where S_AXIS_VALID and S_AXIS_READY are
  // both high; READY depends only on the FIFO fill level and is held low during reset.

  logic [PIXEL_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_wr_ptr;
  logic [ADDR_WIDTH-1:0]  r_rd_ptr;
  logic [ADDR_WIDTH:0]    r_count;
  logic [PIXEL_WIDTH-1:0] r_d_2_vga;
  logic                   r_underflow;

  logic [PIXEL_WIDTH-1:0] w_pixel;
  logic [PIXEL_WIDTH-1:0] w_head;
  logic                   w_active;
  logic                   w_push;
  logic                   w_pop;

  // Replicate each channel's MSBs into the extra low bits so full scale maps to full scale.
  assign w_pixel = {S_AXIS_DATA[7:5], S_AXIS_DATA[7],
                    S_AXIS_DATA[4:2], S_AXIS_DATA[4],
                    S_AXIS_DATA[1:0], S_AXIS_DATA[1:0]};

  assign FIFO_FULL    = (r_count == (ADDR_WIDTH + 1)'(DEPTH));
  assign FIFO_EMPTY   = (r_count == '0);
  assign S_AXIS_READY = i_RSTn & ~FIFO_FULL;

  assign w_head   = r_mem[r_rd_ptr];
  assign w_active = (HC < 11'(H_ACTIVE)) && (VC < 11'(V_ACTIVE));
  assign w_push   = S_AXIS_VALID && S_AXIS_READY;
  assign w_pop    = TICK_25 && w_active && !FIFO_EMPTY;

  always_ff @(posedge i_CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_pixel;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Blanking and starved ticks both drive black; only starvation in the visible area is sticky.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_d_2_vga   <= '0;
      r_underflow <= 1'b0;
    end else if (TICK_25) begin
      if (w_pop) begin
        r_d_2_vga <= w_head;
      end else begin
        r_d_2_vga <= '0;
      end
      if (w_active && FIFO_EMPTY) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign D_2_VGA   = r_d_2_vga;
  assign UNDERFLOW = r_underflow;

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Bench for pixel_stream_buffer: a queue-based FIFO model predicts every pixel and flag,
// and a monitor compares the registered VGA output against the predicted stream.
module tb_pixel_stream_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        tick;
  logic [10:0] hc;
  logic [10:0] vc;
  logic [11:0] d_out;
  logic        full;
  logic        empty;
  logic        uf;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  logic        exp_uf_q[$];
  logic [11:0] model_q[$];
  logic        model_uf;

  pixel_stream_buffer dut (
    .i_CLK        (clk),
    .i_RSTn       (rst_n),
    .S_AXIS_DATA  (s_data),
    .S_AXIS_VALID (s_valid),
    .S_AXIS_READY (s_ready),
    .TICK_25      (tick),
    .HC           (hc),
    .VC           (vc),
    .D_2_VGA      (d_out),
    .FIFO_FULL    (full),
    .FIFO_EMPTY   (empty),
    .UNDERFLOW    (uf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Each 3-bit channel scales to 4 bits as v*15/7 rounded the same way as bit replication;
  // the 2-bit blue channel scales exactly by 5.
  function automatic logic [11:0] expand(input logic [7:0] b);
    int r, g, bl;
    r  = int'(b) / 32;
    g  = (int'(b) / 4) % 8;
    bl = int'(b) % 4;
    return 12'(((r * 2 + r / 4) * 256) + ((g * 2 + g / 4) * 16) + bl * 5);
  endfunction

  // One clock of stimulus; the model advances using the state before the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic t,
                       input logic [10:0] h, input logic [10:0] vv, output logic acc);
    logic        act_px;
    logic [11:0] exp_px;
    @(negedge clk);
    s_valid = v;
    s_data  = d;
    tick    = t;
    hc      = h;
    vc      = vv;
    #1;
    check("ready", int'(s_ready), int'(model_q.size() < 1024));
    check("full",  int'(full),    int'(model_q.size() == 1024));
    check("empty", int'(empty),   int'(model_q.size() == 0));
    acc = v && (model_q.size() < 1024);
    if (t) begin
      act_px = (h < 640) && (vv < 480);
      exp_px = 12'h000;
      if (act_px && model_q.size() > 0) exp_px = model_q.pop_front();
      else if (act_px) model_uf = 1'b1;
      exp_q.push_back(exp_px);
      exp_uf_q.push_back(model_uf);
    end
    if (acc) model_q.push_back(expand(d));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    tick    = 1'b0;
    #1;
    check("ready_in_reset", int'(s_ready), 0);
    check("empty_in_reset", int'(empty), 1);
    check("full_in_reset",  int'(full), 0);
    check("d_in_reset",     int'(d_out), 0);
    repeat (2) @(negedge clk);
    model_q.delete();
    exp_q.delete();
    exp_uf_q.delete();
    model_uf = 1'b0;
    rst_n    = 1'b1;
    s_valid  = 1'b0;
  endtask

  // Monitor: tracks the expected held output and compares it every cycle out of reset.
  initial begin
    logic [11:0] cur;
    logic        cur_uf;
    logic        tick_seen;
    cur    = '0;
    cur_uf = 1'b0;
    forever begin
      @(posedge clk);
      tick_seen = tick && rst_n;
      if (!rst_n) begin
        cur    = '0;
        cur_uf = 1'b0;
      end
      @(negedge clk);
      if (rst_n) begin
        if (tick_seen) begin
          if (exp_q.size() == 0) begin
            check("exp_q_nonempty", 0, 1);
          end else begin
            cur    = exp_q.pop_front();
            cur_uf = exp_uf_q.pop_front();
          end
        end
        check("d_2_vga",   int'(d_out), int'(cur));
        check("underflow", int'(uf),    int'(cur_uf));
      end
    end
  end

  initial begin
    logic        acc;
    logic        pend;
    logic        v;
    logic [7:0]  d;
    logic [7:0]  hold;
    logic [10:0] lines[4];
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    tick     = 1'b0;
    hc       = '0;
    vc       = '0;
    model_uf = 1'b0;
    lines[0] = 11'd0;
    lines[1] = 11'd239;
    lines[2] = 11'd479;
    lines[3] = 11'd480;

    // Reset then idle
    do_reset();
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 11'd0, 11'd0, acc);

    // Known colours
    cycle(1'b1, 8'hFF, 1'b0, 11'd0, 11'd0, acc);
    cycle(1'b1, 8'h00, 1'b0, 11'd0, 11'd0, acc);
    cycle(1'b1, 8'hE0, 1'b0, 11'd0, 11'd0, acc);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 11'd0, 11'd0, acc);
      cycle(1'b0, 8'h00, 1'b0, 11'd0, 11'd0, acc);
    end

    // Fill to full, then hold a beat against backpressure
    for (int i = 0; i < 1024; i++) cycle(1'b1, 8'($urandom), 1'b0, 11'd0, 11'd0, acc);
    hold = 8'($urandom);
    repeat (3) cycle(1'b1, hold, 1'b0, 11'd0, 11'd0, acc);
    cycle(1'b1, hold, 1'b1, 11'd5, 11'd5, acc);
    cycle(1'b1, hold, 1'b0, 11'd5, 11'd5, acc);
    cycle(1'b0, 8'h00, 1'b0, 11'd5, 11'd5, acc);

    // Blanking ticks leave the FIFO untouched
    repeat (6) cycle(1'b0, 8'h00, 1'b1, 11'd700, 11'd0, acc);
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 11'd5, 11'd500, acc);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 11'd640, 11'd479, acc);

    // Drain everything inside the visible area
    for (int i = 0; i < 1024; i++) cycle(1'b0, 8'h00, 1'b1, 11'd100, 11'd100, acc);
    cycle(1'b0, 8'h00, 1'b0, 11'd100, 11'd100, acc);

    // Starved tick, then sticky flag survives new data
    cycle(1'b0, 8'h00, 1'b1, 11'd10, 11'd10, acc);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0, 11'd10, 11'd10, acc);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 11'd639, 11'd479, acc);
    cycle(1'b0, 8'h00, 1'b0, 11'd0, 11'd0, acc);
    do_reset();
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 11'd0, 11'd0, acc);

    // Random traffic across sampled lines, with a reset in the middle
    pend = 1'b0;
    d    = '0;
    for (int l = 0; l < 4; l++) begin
      if (l == 2) begin
        cycle(1'b0, 8'h00, 1'b0, 11'd0, lines[l], acc);
        do_reset();
        pend = 1'b0;
      end
      for (int h = 0; h < 800; h++) begin
        for (int ph = 0; ph < 2; ph++) begin
          if (pend) v = 1'b1;
          else begin
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom);
          end
          cycle(v, d, 1'(ph == 0), 11'(h), lines[l], acc);
          pend = v && !acc;
        end
      end
    end

    repeat (4) cycle(1'b0, 8'h00, 1'b0, 11'd0, 11'd0, acc);
    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
